// File: rtl/axis_frame_len_mon.sv
// Passive AXI-Stream frame length monitor.
// Measures each frame, flags runt/oversize/sat/bad, queues results.
module axis_frame_len_mon #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned MIN_LEN     = 64,
  parameter int unsigned MAX_LEN     = 1518,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  input  logic                  monitor_axis_tuser,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic [3:0]            m_flags,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  in_frame,
  output logic [15:0]           drop_count,
  output logic                  drop_pulse
);

  localparam int unsigned CW = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned SW = LEN_WIDTH + CW;
  localparam int unsigned XW = LEN_WIDTH + 32;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = LEN_WIDTH + 4;

  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic                 bad_q, bad_d;
  logic                 in_frame_q, in_frame_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 drop_pulse_q;

  logic [RW-1:0]        mem [FIFO_DEPTH];

  logic [CW-1:0]        beat_size;
  logic [SW-1:0]        sum;
  logic                 ovf;
  logic [LEN_WIDTH-1:0] acc_sum;
  logic                 beat;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 drop;
  logic                 wr_en;
  logic                 res_runt;
  logic                 res_over;
  logic [RW-1:0]        res;
  logic [RW-1:0]        head;

  always_comb begin
    beat_size = '0;
    if (KEEP_ENABLE) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        beat_size = beat_size + CW'(monitor_axis_tkeep[i]);
      end
    end else begin
      beat_size = CW'(1);
    end
  end

  assign beat = monitor_axis_tvalid && monitor_axis_tready;
  assign sum  = SW'(acc_q) + SW'(beat_size);
  assign ovf  = |sum[SW-1:LEN_WIDTH];
  assign acc_sum = ovf ? '1 : sum[LEN_WIDTH-1:0];

  // Length checks run on the saturated total.
  assign res_runt = XW'(acc_sum) < XW'(MIN_LEN);
  assign res_over = XW'(acc_sum) > XW'(MAX_LEN);
  assign res = {sat_q | ovf, bad_q | monitor_axis_tuser,
                res_over, res_runt, acc_sum};

  assign m_valid = !rst && (cnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign full    = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign push    = beat && monitor_axis_tlast;
  assign drop    = push && full && !pop;
  assign wr_en   = push && !drop;

  always_comb begin
    acc_d      = acc_q;
    sat_d      = sat_q;
    bad_d      = bad_q;
    in_frame_d = in_frame_q;
    if (beat) begin
      if (monitor_axis_tlast) begin
        acc_d      = '0;
        sat_d      = 1'b0;
        bad_d      = 1'b0;
        in_frame_d = 1'b0;
      end else begin
        acc_d      = acc_sum;
        sat_d      = sat_q | ovf;
        bad_d      = bad_q | monitor_axis_tuser;
        in_frame_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      sat_q        <= 1'b0;
      bad_q        <= 1'b0;
      in_frame_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      bad_q        <= bad_d;
      in_frame_q   <= in_frame_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr_q] <= res;
    end
  end

  assign head       = m_valid ? mem[rd_ptr_q] : '0;
  assign m_len      = head[LEN_WIDTH-1:0];
  assign m_flags    = head[RW-1:LEN_WIDTH];
  assign in_frame   = in_frame_q;
  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_axis_frame_len_mon.sv
// Bench for axis_frame_len_mon: directed cases plus random frames
// checked against a queue-based reference model.
module tb_axis_frame_len_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast, tuser;
  logic        m_ready;

  logic [15:0] m_len;
  logic [3:0]  m_flags;
  logic        m_valid, in_frame, drop_pulse;
  logic [15:0] drop_count;

  logic [7:0]  m_len2;
  logic [3:0]  m_flags2;
  logic        m_valid2, in_frame2, drop_pulse2;
  logic [15:0] drop_count2;

  always #5 clk = ~clk;

  axis_frame_len_mon dut (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep),
    .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready),
    .monitor_axis_tlast(tlast),
    .monitor_axis_tuser(tuser),
    .m_len(m_len), .m_flags(m_flags),
    .m_valid(m_valid), .m_ready(m_ready),
    .in_frame(in_frame),
    .drop_count(drop_count), .drop_pulse(drop_pulse)
  );

  axis_frame_len_mon #(.LEN_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(tkeep),
    .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready),
    .monitor_axis_tlast(tlast),
    .monitor_axis_tuser(tuser),
    .m_len(m_len2), .m_flags(m_flags2),
    .m_valid(m_valid2), .m_ready(1'b1),
    .in_frame(in_frame2),
    .drop_count(drop_count2), .drop_pulse(drop_pulse2)
  );

  typedef struct packed {
    logic [15:0] len;
    logic [3:0]  fl;
  } res_t;

  res_t q[$];
  int   acc = 0, acc8 = 0, mdrop = 0;
  bit   sat = 0, bad = 0, inf = 0, mpulse = 0;
  bit   sat8 = 0, bad8 = 0, pend8 = 0;
  logic [7:0] plen8 = '0;
  logic [3:0] pfl8 = '0;
  int   nassert = 0, nfail = 0, pulses = 0;

  task automatic ck(input string tag, input logic [31:0] obs,
                    input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ck("m_valid", 32'(m_valid), 32'(q.size() != 0));
    ck("m_len", 32'(m_len), 32'(q.size() != 0 ? q[0].len : 16'h0));
    ck("m_flags", 32'(m_flags), 32'(q.size() != 0 ? q[0].fl : 4'h0));
    ck("in_frame", 32'(in_frame), 32'(inf));
    ck("drop_count", 32'(drop_count), 32'(mdrop));
    ck("drop_pulse", 32'(drop_pulse), 32'(mpulse));
    ck("m_valid8", 32'(m_valid2), 32'(pend8));
    ck("m_len8", 32'(m_len2), 32'(pend8 ? plen8 : 8'h0));
    ck("m_flags8", 32'(m_flags2), 32'(pend8 ? pfl8 : 4'h0));
    ck("in_frame8", 32'(in_frame2), 32'(inf));
    ck("drop_count8", 32'(drop_count2), 32'd0);
  endtask

  // Reference: frame length = sum of tkeep popcounts, clamped to the
  // accumulator maximum; results queue of depth 4, drop when full.
  task automatic model_step();
    bit   beat, pop, full, s, b, s8, b8;
    int   sz, tot, t8;
    res_t r;
    if (rst) begin
      acc = 0; sat = 0; bad = 0; inf = 0;
      q.delete(); mdrop = 0; mpulse = 0;
      acc8 = 0; sat8 = 0; bad8 = 0; pend8 = 0;
      return;
    end
    beat = tvalid && tready;
    pop  = (q.size() != 0) && m_ready;
    full = q.size() == 4;
    mpulse = 0;
    pend8  = 0;
    if (pop) r = q.pop_front();
    if (beat) begin
      sz  = $countones(tkeep);
      tot = acc + sz;
      s   = sat || (tot > 65535);
      if (tot > 65535) tot = 65535;
      t8  = acc8 + sz;
      s8  = sat8 || (t8 > 255);
      if (t8 > 255) t8 = 255;
      b   = bad || tuser;
      b8  = bad8 || tuser;
      if (tlast) begin
        r.len = 16'(tot);
        r.fl  = {s, b, tot > 1518, tot < 64};
        if (full && !pop) begin
          if (mdrop < 65535) mdrop++;
          mpulse = 1;
        end else begin
          q.push_back(r);
        end
        pend8 = 1;
        plen8 = 8'(t8);
        pfl8  = {s8, b8, t8 > 1518, t8 < 64};
        acc = 0; sat = 0; bad = 0;
        acc8 = 0; sat8 = 0; bad8 = 0;
        inf = 0;
      end else begin
        acc = tot; sat = s; bad = b;
        acc8 = t8; sat8 = s8; bad8 = b8;
        inf = 1;
      end
    end
  endtask

  task automatic tick();
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] k, input logic l, input logic u);
    tvalid = 1'b1; tready = 1'b1;
    tkeep = k; tlast = l; tuser = u;
    tick();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input int n, input logic [7:0] lk, input int ub);
    for (int i = 0; i < n; i++) begin
      send((i == n - 1) ? lk : 8'hFF, i == n - 1, i == ub);
    end
  endtask

  initial begin
    int e4[4];
    int n;
    rst = 1'b1; m_ready = 1'b1;
    tvalid = 1'b1; tready = 1'b1; tkeep = 8'hFF;
    tlast = 1'b1; tuser = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    ck("rst_valid", 32'(m_valid), 32'd0);
    ck("rst_len", 32'(m_len), 32'd0);
    ck("rst_flags", 32'(m_flags), 32'd0);
    rst = 1'b0;
    tvalid = 1'b0; tlast = 1'b0;
    idle(2);

    frame(9, 8'h0F, -1);
    ck("f68_valid", 32'(m_valid), 32'd1);
    ck("f68_len", 32'(m_len), 32'd68);
    ck("f68_flags", 32'(m_flags), 32'd0);
    idle(2);

    send(8'hFF, 1'b1, 1'b0);
    ck("f8_len", 32'(m_len), 32'd8);
    ck("f8_flags", 32'(m_flags), 32'b0001);
    ck("f8_inframe", 32'(in_frame), 32'd0);
    idle(2);

    frame(200, 8'hFF, 4);
    ck("f1600_len", 32'(m_len), 32'd1600);
    ck("f1600_flags", 32'(m_flags), 32'b0110);
    ck("f1600_len8", 32'(m_len2), 32'd255);
    ck("f1600_flags8", 32'(m_flags2), 32'b1100);
    idle(2);

    frame(40, 8'hFF, -1);
    ck("f320_len", 32'(m_len), 32'd320);
    ck("f320_flags", 32'(m_flags), 32'd0);
    ck("sat8_len", 32'(m_len2), 32'd255);
    ck("sat8_flags", 32'(m_flags2), 32'b1000);
    idle(2);

    m_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'((1 << (i + 1)) - 1), 1'b1, 1'b0);
      pulses += int'(drop_pulse);
    end
    idle(1);
    pulses += int'(drop_pulse);
    ck("full_pulses", 32'(pulses), 32'd2);
    ck("full_drops", 32'(drop_count), 32'd2);
    ck("full_head", 32'(m_len), 32'd1);
    m_ready = 1'b1;
    send(8'h7F, 1'b1, 1'b0);
    ck("pushpop_drops", 32'(drop_count), 32'd2);
    ck("pushpop_pulse", 32'(drop_pulse), 32'd0);
    e4 = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) begin
      ck("order_len", 32'(m_len), 32'(e4[i]));
      idle(1);
    end
    ck("drained", 32'(m_valid), 32'd0);

    for (int i = 0; i < 3; i++) send(8'hFF, 1'b0, 1'b0);
    ck("abort_inframe", 32'(in_frame), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ck("abort_inframe0", 32'(in_frame), 32'd0);
    ck("abort_valid", 32'(m_valid), 32'd0);
    frame(2, 8'hFF, -1);
    ck("f16_len", 32'(m_len), 32'd16);
    ck("f16_flags", 32'(m_flags), 32'b0001);
    idle(2);

    for (int f = 0; f < 60; f++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(180, 220))
                                      : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          tvalid = 1'($urandom);
          tready = ~tvalid;
          tkeep  = 8'($urandom);
          tlast  = 1'($urandom);
          tuser  = 1'($urandom);
          m_ready = 1'($urandom);
          tick();
        end
        tvalid = 1'b1; tready = 1'b1;
        tkeep  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        tlast  = (i == n - 1);
        tuser  = ($urandom_range(0, 15) == 0);
        m_ready = ($urandom_range(0, 2) != 0);
        tick();
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      end
    end
    m_ready = 1'b1;
    idle(6);
    ck("end_empty", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
